hybrid_cla_pipe_adder: RTL and testbench



---
 rtl/hadd_pkg.sv | 28 ++
 rtl/hybrid_cla_pipe_adder_cla_group.sv | 37 +++
 rtl/hybrid_cla_pipe_adder.sv | 165 ++++++++++++++++
 tb/tb_hybrid_cla_pipe_adder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hadd_pkg.sv
// Shared constants, operation type and saturation helpers for the pipelined hybrid CLA adder.
package hadd_pkg;

    localparam int unsigned GROUP_MIN = 2;
    localparam int unsigned GROUP_MAX = 8;
    localparam int unsigned SAT_W_MAX = 1024;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of lookahead groups (and pipeline stages) for a given width.
    function automatic int unsigned ngrp(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

    // Largest positive two's-complement value of the given width, right-aligned.
    function automatic logic [SAT_W_MAX-1:0] max_pos(input int unsigned width);
        return {SAT_W_MAX{1'b1}} >> (SAT_W_MAX - width + 1);
    endfunction

    // Most negative two's-complement value of the given width, right-aligned.
    function automatic logic [SAT_W_MAX-1:0] max_neg(input int unsigned width);
        return SAT_W_MAX'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/hybrid_cla_pipe_adder_cla_group.sv
// One GROUP-bit carry-lookahead slice: sum, group carry-out and carry into the slice MSB.
module cla_group #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             gg;
    logic             gp;

    // Every carry is formed directly from cin and the running group P/G prefix.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        gg   = 1'b0;
        gp   = 1'b1;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(GROUP); i++) begin
            gg       = g[i] | (p[i] & gg);
            gp       = gp & p[i];
            c[i + 1] = gg | (gp & cin);
        end
        sum  = p ^ c[GROUP-1:0];
        cout = c[GROUP];
        cmsb = c[GROUP-1];
    end

endmodule

// File: rtl/hybrid_cla_pipe_adder.sv
// Pipelined hybrid carry-lookahead add/subtract: one CLA group per register stage,
// skewed operands, deskewed sum, valid/ready handshake with a single global stall.
// Optional signed saturation is built when macro HADD_SAT_EN is defined.
module hybrid_cla_pipe_adder
    import hadd_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Xi,
    input  logic [WIDTH-1:0] Yi,
    input  logic             C0,
    input  logic             sub,
`ifdef HADD_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Si,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned NGRP = ngrp(WIDTH, GROUP);

    logic                           en;
    op_e                            op;
    logic                           cin0;
    logic [WIDTH-1:0]               y_eff;

    logic [NGRP-1:0]                v_q;
    logic [NGRP-1:0]                c_q;
    logic [WIDTH-1:0]               x_q [NGRP];
    logic [WIDTH-1:0]               y_q [NGRP];
    logic [WIDTH-1:0]               s_q [NGRP];
    logic                           ovf_q;

    logic [NGRP-1:0]                v_in;
    logic [NGRP-1:0]                c_in;
    logic [NGRP-1:0][WIDTH-1:0]     x_in;
    logic [NGRP-1:0][WIDTH-1:0]     y_in;
    logic [NGRP-1:0][WIDTH-1:0]     s_in;
    logic [NGRP-1:0][WIDTH-1:0]     s_nxt;
    logic [NGRP-1:0][GROUP-1:0]     gsum;
    logic [NGRP-1:0]                gcout;
    logic [NGRP-1:0]                gcmsb;

    logic [WIDTH-1:0]               s_fin;
    logic                           ovf_fin;
    logic                           unused_cmsb;

`ifdef HADD_SAT_EN
    logic [NGRP-1:0]                sat_in;
    logic [NGRP-1:0]                sat_q;
    logic                           unused_sat;
    assign unused_sat = sat_q[NGRP-1];
`endif

    // Only the top group's MSB carry feeds overflow; lower groups' copies are don't-care.
    assign unused_cmsb = ^gcmsb;

    // Global stall: the whole pipe moves only when the output slot is free or being taken.
    assign en        = ~v_q[NGRP-1] | out_ready;
    assign in_ready  = en & ~rst;
    assign out_valid = v_q[NGRP-1];
    assign Si        = s_q[NGRP-1];
    assign Cout      = c_q[NGRP-1];
    assign Ovf       = ovf_q;

    // Operand conditioning: subtract inverts Y up front and forces carry-in high.
    always_comb begin
        op    = sub ? OP_SUB : OP_ADD;
        y_eff = (op == OP_SUB) ? ~Yi : Yi;
        cin0  = (op == OP_SUB) ? 1'b1 : C0;
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k] = in_valid;
            assign x_in[k] = Xi;
            assign y_in[k] = y_eff;
            assign s_in[k] = '0;
            assign c_in[k] = cin0;
`ifdef HADD_SAT_EN
            assign sat_in[k] = sat;
`endif
        end else begin : g_body
            assign v_in[k] = v_q[k-1];
            assign x_in[k] = x_q[k-1];
            assign y_in[k] = y_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
`ifdef HADD_SAT_EN
            assign sat_in[k] = sat_q[k-1];
`endif
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_cla (
            .a    (x_in[k][k*GROUP +: GROUP]),
            .b    (y_in[k][k*GROUP +: GROUP]),
            .cin  (c_in[k]),
            .sum  (gsum[k]),
            .cout (gcout[k]),
            .cmsb (gcmsb[k])
        );
    end

    // Each stage merges its fresh slice into the deskewed sum word it received.
    always_comb begin
        for (int k = 0; k < int'(NGRP); k++) begin
            s_nxt[k]                    = s_in[k];
            s_nxt[k][k*GROUP +: GROUP]  = gsum[k];
        end
    end

    // Final stage: overflow from the top group's carries, optional saturation of the word.
    always_comb begin
        ovf_fin = gcmsb[NGRP-1] ^ gcout[NGRP-1];
        s_fin   = s_nxt[NGRP-1];
`ifdef HADD_SAT_EN
        if (sat_in[NGRP-1] && ovf_fin) begin
            s_fin = gcout[NGRP-1] ? WIDTH'(max_neg(WIDTH)) : WIDTH'(max_pos(WIDTH));
        end
`endif
    end

    // Pipeline registers: valid, carry, skewed operands and deskewed sums advance together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
`ifdef HADD_SAT_EN
            sat_q <= '0;
`endif
            for (int k = 0; k < int'(NGRP); k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            v_q   <= v_in;
            c_q   <= gcout;
            ovf_q <= ovf_fin;
`ifdef HADD_SAT_EN
            sat_q <= sat_in;
`endif
            for (int k = 0; k < int'(NGRP) - 1; k++) begin
                x_q[k] <= x_in[k];
                y_q[k] <= y_in[k];
                s_q[k] <= s_nxt[k];
            end
            x_q[NGRP-1] <= x_in[NGRP-1];
            y_q[NGRP-1] <= y_in[NGRP-1];
            s_q[NGRP-1] <= s_fin;
        end
    end

endmodule

// File: tb/tb_hybrid_cla_pipe_adder.sv
// Scoreboard bench for hybrid_cla_pipe_adder (32-bit main instance, 8-bit directed instance).
module tb_hybrid_cla_pipe_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned G  = 4;
    localparam int unsigned NG = W / G;

    typedef struct {
        logic [31:0] si;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Xi = '0;
    logic [31:0] Yi = '0;
    logic        C0 = 1'b0;
    logic        sub = 1'b0;
    logic        sat_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Si;
    logic        Cout;
    logic        Ovf;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  x8 = '0;
    logic [7:0]  y8 = '0;
    logic        out_valid8;
    logic [7:0]  s8;
    logic        cout8;
    logic        ovf8;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    bit   rnd_done    = 1'b0;

    always #5 clk = ~clk;

    hybrid_cla_pipe_adder #(.WIDTH(W), .GROUP(G)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Xi        (Xi),
        .Yi        (Yi),
        .C0        (C0),
        .sub       (sub),
`ifdef HADD_SAT_EN
        .sat       (sat_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Si        (Si),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    hybrid_cla_pipe_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .Xi        (x8),
        .Yi        (y8),
        .C0        (1'b0),
        .sub       (1'b0),
`ifdef HADD_SAT_EN
        .sat       (1'b0),
`endif
        .out_valid (out_valid8),
        .out_ready (1'b1),
        .Si        (s8),
        .Cout      (cout8),
        .Ovf       (ovf8)
    );

    // Reference: plain integer arithmetic on the operands as numbers.
    function automatic exp_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                       input logic c0, input logic s, input logic st);
        exp_t           e;
        longint         sx;
        longint         sy;
        longint         r;
        longint unsigned u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r      = sx - sy;
            e.si   = x - y;
            e.cout = (x >= y);
        end else begin
            u      = 64'(x) + 64'(y) + 64'(c0);
            r      = sx + sy + longint'(c0);
            e.si   = u[31:0];
            e.cout = u[32];
        end
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef HADD_SAT_EN
        if (st && e.ovf) e.si = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
        if (st) e.si = e.si;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h0000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c0, input logic s);
        int n = 0;
        Xi = x; Yi = y; C0 = c0; sub = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Accept watcher: record the expected result of every handshake.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back(ref_model(Xi, Yi, C0, sub, sat_i));
    end

    // Monitor: retire results in order; hold must present the head result unchanged.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                chk("result{cout,ovf,si}", {30'd0, Cout, Ovf, Si}, {30'd0, e.cout, e.ovf, e.si});
            end else begin
                chk("stall_hold_si", 64'(Si), 64'(exp_q[0].si));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt;

        // Reset state.
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_si", 64'(Si), 64'd0);
        chk("rst_cout_ovf", {62'd0, Cout, Ovf}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // 8-bit instance: 0x3C + 0x45 two cycles later.
        x8 = 8'h3C; y8 = 8'h45; in_valid8 = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("w8_not_yet_valid", 64'(out_valid8), 64'd0);
        @(negedge clk);
        chk("w8_result{v,cout,ovf,s}", {53'd0, out_valid8, cout8, ovf8, s8}, {53'd0, 1'b1, 1'b0, 1'b1, 8'h81});
        @(posedge clk); #1;

        // Latency on an idle pipe.
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        chk("latency", 64'(cyc), 64'(NG));
        drain();

        // Back-to-back carry/overflow boundaries, then subtract with ignored C0.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        drain();

`ifdef HADD_SAT_EN
        sat_i = 1'b1;
        send(32'h7FFF_FFF0, 32'h0000_0020, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        sat_i = 1'b0;
        send(32'h7FFF_FFF0, 32'h0000_0020, 1'b0, 1'b0);
        drain();
`endif

        // Backpressure: 10 ops, consumer stalls cycles 9..14.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(32'(i) * 32'h0101_0101, 32'h00FF_00FF + 32'(i), 1'(i % 2), 1'(i % 3 == 0));
            end
            begin
                for (int c = 0; c < 17; c++) begin
                    out_ready = !(c >= 9 && c <= 14);
                    @(negedge clk);
                    if (c >= 9 && c <= 14) chk("stall_in_ready", 64'(in_ready), 64'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Randomized traffic with bubbles and random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight with a stalled result at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'hA000_0000 + 32'(i), 32'h0000_0100, 1'b0, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("prefill_out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_outputs", {30'd0, Cout, Ovf, Si}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_after_midrst", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("no_stale_after_rst", 64'(cnt), 64'd0);

        // Traffic still flows after reset.
        @(posedge clk); #1;
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
